// File: rtl/stage12_fifo_ctrl.sv
// Sequencer for the 12-deep layer-3 line-buffer delay line feeding a 3x3 convolution window.
// Define STAGE12_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module stage12_fifo_ctrl #(
  parameter int unsigned IMG_W = 15,
  parameter int unsigned IMG_H = 15,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          done
`ifdef STAGE12_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          acc;
  logic          last_pix;

  always_comb begin
    in_ready = (state_q == StRun) && !(win_valid_q && !win_ready);
    acc      = in_valid && in_ready;
    shift_en = acc;
    last_pix = (row_q == RowLast) && (col_q == ColLast);
    done     = (state_q == StFlush) && (!win_valid_q || win_ready);
    busy     = (state_q != StIdle);

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (acc && last_pix) state_d = StFlush;
      end
      StFlush: begin
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (acc) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // A new window overrides consumption of the old one in the same cycle.
    if (acc && (row_q >= RW'(2)) && (col_q >= CW'(2))) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - RW'(2);
      win_col_d   = col_q - CW'(2);
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

`ifdef STAGE12_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StIdle) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == StRun) && in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/stage12_fifo_ctrl.md
Name: stage12_fifo_ctrl

Overview:
- Sequencer for the 12-deep, 128-bit layer-3 weight-input delay line used as a line buffer in a 3x3 convolution window.
- Accepts a raster-ordered pixel stream over valid/ready and drives the delay line's shift enable.
- Tracks the row and column position, and flags when a complete 3x3 window is present.
- Applies back-pressure when the downstream window consumer stalls.

Parameters:
- IMG_W, 15, feature-map width in pixels. Delay-line depth 12 = IMG_W-3.
- IMG_H, 15, feature-map height in pixels.
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse that begins a frame. Ignored unless in IDLE.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  controller can accept a pixel.
- shift_en  output  1  advance the delay line and window registers this cycle.
- win_valid  output  1  a full 3x3 window is present at the delay-line taps.
- win_ready  input  1  downstream consumes the window.
- win_row  output  RW  window top-left row, 0..IMG_H-3.
- win_col  output  CW  window top-left column, 0..IMG_W-3.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- States: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start.
  - RUN -> FLUSH on acceptance of the last pixel (row=IMG_H-1, col=IMG_W-1).
  - FLUSH -> IDLE when win_valid is 0, or when win_valid && win_ready. done=1 for exactly that transition cycle.
- in_ready = (state==RUN) && !(win_valid && !win_ready). This is combinational.
- Accept condition: acc = in_valid && in_ready. shift_en = acc, combinational, in the same cycle.
- Counters col and row are registered and reset to 0 on entering RUN.
  - On acc: col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - No other updates.
- Window emission is registered, one cycle after acc:
  - If the accepted pixel had row>=2 && col>=2, then win_valid<=1, win_row<=row-2, win_col<=col-2.
  - Else, if win_ready, win_valid<=0.
- win_valid holds with stable win_row/win_col until win_ready. A new window and the consumption of the old one can occur in the same cycle; the new window wins.
- Windows per frame = (IMG_W-2)*(IMG_H-2) = 169 at defaults.
- Windows are not emitted for pixels with col<2. Row wrap never creates a cross-row window.
- start while busy is ignored. in_valid while in IDLE or FLUSH is not accepted (in_ready=0).
- Reset values, also applied on rst asserted mid-frame: state=IDLE; in_ready=0; shift_en=0; win_valid=0; win_row=0; win_col=0; busy=0; done=0; counters=0.
- Delay-line contents after reset are don't-care. The first IMG_W*2+2 accepted pixels refill them before any window is emitted.

Optional Feature:
- STAGE12_CTRL_STALL_CNT_EN
  - When defined, adds output port stall_cnt (16 bits).
  - stall_cnt counts cycles with state==RUN && in_valid && !in_ready.
  - It saturates at 0xFFFF, clears on start, resets to 0, and holds its value after done.
- When undefined, the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0; in_valid=1 gives in_ready=0 and shift_en=0.
- Full frame, no stalls: start, in_valid=1, win_ready=1 for 225 pixels -> 225 shift_en pulses, 169 win_valid cycles.
  - First window (0,0) appears the cycle after the 33rd accepted pixel.
  - Last window is (12,12). done pulses once, then busy=0.
- Back-pressure: hold win_ready=0 when window (0,0) appears -> in_ready=0 and shift_en=0 for every held cycle; win_row/win_col stay 0/0.
  - Release win_ready -> exactly one consume, stream resumes, no window is lost or duplicated.
- Row wrap: accepted pixels at (2,14) then (3,0) and (3,1) -> window (0,12), then no window for cols 0 and 1; the next window is (1,0) at pixel (3,2).
- Mid-frame reset and restart: assert rst after 100 pixels, then a new start -> outputs at reset values; the new frame restarts at (0,0) and yields 169 windows. start pulses issued during busy are ignored.
- Macro build: define STAGE12_CTRL_STALL_CNT_EN, stall win_ready for 7 cycles with in_valid=1 -> stall_cnt=7; next start -> stall_cnt=0.
